// File: rtl/kuz_pkg.sv
// Kuznechik constants and helpers: PI / PI_INV S-boxes, L coefficients, GF(2^8) multiply.
// PI_INV and the inverse S-layer exist only when KUZ_DECRYPT_EN is defined.
package kuz_pkg;

    typedef enum logic [1:0] {IDLE, XS, LIN, FIN} state_t;
    typedef logic [7:0] sbox_t [256];

    localparam logic [7:0] GF_POLY = 8'hC3;

    localparam sbox_t PI = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // L_COEF[i] multiplies byte a(15-i)
    localparam logic [7:0] L_COEF [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] l_func(input logic [127:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 16; i++)
            r = r ^ gf_mul(a[127-8*i -: 8], L_COEF[i]);
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] a);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = PI[a[8*i +: 8]];
        return r;
    endfunction

`ifdef KUZ_DECRYPT_EN
    function automatic sbox_t build_pi_inv();
        sbox_t t;
        for (int i = 0; i < 256; i++)
            t[PI[i]] = 8'(i);
        return t;
    endfunction

    localparam sbox_t PI_INV = build_pi_inv();

    function automatic logic [127:0] sub_bytes_inv(input logic [127:0] a);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = PI_INV[a[8*i +: 8]];
        return r;
    endfunction
`endif

endpackage

// File: rtl/kuz_r_step.sv
// One LFSR step of the Kuznechik linear layer: R when inv=0, R^-1 when inv=1.
module kuz_r_step
    import kuz_pkg::*;
(
    input  logic [127:0] a,
    input  logic         inv,
    output logic [127:0] y
);

    always_comb begin
        if (inv)
            y = {a[119:0], l_func({a[119:0], a[127:120]})};
        else
            y = {l_func(a), a[127:8]};
    end

endmodule

// File: rtl/kuz_core_top.sv
// Iterative Kuznechik block cipher: one S-layer or one R-step per clock.
// Optional KUZ_DECRYPT_EN adds the decrypt port and the inverse datapath.
//   state | meaning
//   IDLE  | waiting for start with keys_valid
//   XS    | key XOR + S-layer (decrypt: S^-1 then key XOR)
//   LIN   | 16 R (or R^-1) steps, counted by rcnt
//   FIN   | final whitening, registers data_out and done
module kuznechik_encrypt_core
    import kuz_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         keys_valid,
    input  logic         start,
    input  logic [127:0] data_in,
`ifdef KUZ_DECRYPT_EN
    input  logic         decrypt,
`endif
    input  logic [127:0] key_1,
    input  logic [127:0] key_2,
    input  logic [127:0] key_3,
    input  logic [127:0] key_4,
    input  logic [127:0] key_5,
    input  logic [127:0] key_6,
    input  logic [127:0] key_7,
    input  logic [127:0] key_8,
    input  logic [127:0] key_9,
    input  logic [127:0] key_10,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out
);

    state_t        state, state_nxt;
    logic [127:0]  st, r_out, xs_val, round_key;
    logic [3:0]    round, rcnt;
    logic          accept, abort, dec, dec_req;

`ifdef KUZ_DECRYPT_EN
    assign dec_req = decrypt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         dec <= 1'b0;
        else if (accept) dec <= decrypt;
    end
`else
    assign dec_req = 1'b0;
    assign dec     = 1'b0;
`endif

    kuz_r_step u_r_step (.a(st), .inv(dec), .y(r_out));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) state_nxt = IDLE;
        else begin
            case (state)
                IDLE: if (accept) state_nxt = dec_req ? LIN : XS;
                XS:   state_nxt = (dec && round == 4'd1) ? FIN : LIN;
                LIN:  if (rcnt == 4'd15) state_nxt = (!dec && round == 4'd9) ? FIN : XS;
                FIN:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        accept = (state == IDLE) && start && keys_valid;
        abort  = (state != IDLE) && !keys_valid;
        case (round)
            4'd1:    round_key = key_1;
            4'd2:    round_key = key_2;
            4'd3:    round_key = key_3;
            4'd4:    round_key = key_4;
            4'd5:    round_key = key_5;
            4'd6:    round_key = key_6;
            4'd7:    round_key = key_7;
            4'd8:    round_key = key_8;
            4'd9:    round_key = key_9;
            default: round_key = key_10;
        endcase
`ifdef KUZ_DECRYPT_EN
        xs_val = dec ? (sub_bytes_inv(st) ^ round_key) : sub_bytes(st ^ round_key);
`else
        xs_val = sub_bytes(st ^ round_key);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= '0;
            round    <= '0;
            rcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        st    <= dec_req ? (data_in ^ key_10) : data_in;
                        round <= dec_req ? 4'd9 : 4'd1;
                        rcnt  <= '0;
                        busy  <= 1'b1;
                    end
                    XS: begin
                        st   <= xs_val;
                        rcnt <= '0;
                        if (dec) round <= round - 4'd1;
                    end
                    LIN: begin
                        st   <= r_out;
                        rcnt <= rcnt + 4'd1;
                        if (rcnt == 4'd15 && !dec && round != 4'd9) round <= round + 4'd1;
                    end
                    FIN: begin
                        data_out <= dec ? st : (st ^ key_10);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
